// File: rtl/tmr_vote_monitor.sv
// Majority voter for triplicated lanes with per-lane mismatch counters, persistence
// tracking, a 4-state health FSM, degradation interrupt and a req/ack clear handshake.
module tmr_vote_monitor #(
  parameter int WIDTH   = 1,
  parameter int CNT_W   = 8,
  parameter int PERSIST = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [WIDTH-1:0] inC,
  output logic [WIDTH-1:0] voted,
  output logic             errA,
  output logic             errB,
  output logic             errC,
  output logic [CNT_W-1:0] cntA,
  output logic [CNT_W-1:0] cntB,
  output logic [CNT_W-1:0] cntC,
  output logic [1:0]       state,
  output logic             irq,
  input  logic             clr_req,
  output logic             clr_ack
);

  localparam int RUN_W = (PERSIST < 2) ? 1 : $clog2(PERSIST + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(PERSIST);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    NOMINAL  = 2'd0,
    SUSPECT  = 2'd1,
    DEGRADED = 2'd2,
    FAULT    = 2'd3
  } state_t;

  function automatic logic [1:0] count3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

  logic [WIDTH-1:0] voted_r;
  logic [2:0]       err_r;
  logic [CNT_W-1:0] cnt_r [3];
  logic [RUN_W-1:0] run_r [3];
  state_t           state_r;
  logic             irq_r;
  logic             ack_r;
  logic             armed_r;

  logic [WIDTH-1:0] maj_s;
  logic [WIDTH-1:0] lane_s [3];
  logic [2:0]       mis_s;
  logic [2:0]       fail_s;
  logic [1:0]       nmis_s;
  logic [1:0]       nfail_s;
  logic             clear_s;
  logic [CNT_W-1:0] cnt_next_s [3];
  logic [RUN_W-1:0] run_next_s [3];
  state_t           state_next_s;
  logic             irq_next_s;

  // Vote, per-lane mismatch/persistence bookkeeping and health next-state
  always_comb begin
    maj_s     = (inA & inB) | (inB & inC) | (inA & inC);
    lane_s[0] = inA;
    lane_s[1] = inB;
    lane_s[2] = inC;
    clear_s   = clr_req && armed_r;
    mis_s     = 3'b000;
    fail_s    = 3'b000;
    for (int k = 0; k < 3; k++) begin
      mis_s[k] = (lane_s[k] != maj_s);
      if (mis_s[k]) begin
        cnt_next_s[k] = (cnt_r[k] == CNT_MAX) ? cnt_r[k] : cnt_r[k] + CNT_W'(1);
        run_next_s[k] = (run_r[k] == RUN_MAX) ? run_r[k] : run_r[k] + RUN_W'(1);
      end else begin
        cnt_next_s[k] = cnt_r[k];
        run_next_s[k] = '0;
      end
      fail_s[k] = (run_next_s[k] == RUN_MAX);
    end
    nmis_s  = count3(mis_s);
    nfail_s = count3(fail_s);

    case (state_r)
      FAULT: state_next_s = FAULT;
      DEGRADED: begin
        if (nmis_s >= 2'd2 || nfail_s >= 2'd2) state_next_s = FAULT;
        else                                   state_next_s = DEGRADED;
      end
      default: begin
        if (nmis_s >= 2'd2 || nfail_s >= 2'd2) state_next_s = FAULT;
        else if (nfail_s == 2'd1)              state_next_s = DEGRADED;
        else if (nmis_s == 2'd1)               state_next_s = SUSPECT;
        else                                   state_next_s = NOMINAL;
      end
    endcase
    irq_next_s = (state_next_s == DEGRADED || state_next_s == FAULT) &&
                 (state_next_s != state_r);

    // A clear edge discards this cycle's counting and any transition
    if (clear_s) begin
      for (int k = 0; k < 3; k++) begin
        cnt_next_s[k] = '0;
        run_next_s[k] = '0;
      end
      state_next_s = NOMINAL;
      irq_next_s   = 1'b0;
    end else begin
      irq_next_s   = irq_next_s;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      voted_r <= '0;
      err_r   <= 3'b000;
      for (int k = 0; k < 3; k++) begin
        cnt_r[k] <= '0;
        run_r[k] <= '0;
      end
      state_r <= NOMINAL;
      irq_r   <= 1'b0;
      ack_r   <= 1'b0;
      armed_r <= 1'b1;
    end else begin
      voted_r <= maj_s;
      err_r   <= mis_s;
      for (int k = 0; k < 3; k++) begin
        cnt_r[k] <= cnt_next_s[k];
        run_r[k] <= run_next_s[k];
      end
      state_r <= state_next_s;
      irq_r   <= irq_next_s;
      ack_r   <= clear_s;
      if (clear_s)       armed_r <= 1'b0;
      else if (!clr_req) armed_r <= 1'b1;
      else               armed_r <= armed_r;
    end
  end

  assign voted   = voted_r;
  assign errA    = err_r[0];
  assign errB    = err_r[1];
  assign errC    = err_r[2];
  assign cntA    = cnt_r[0];
  assign cntB    = cnt_r[1];
  assign cntC    = cnt_r[2];
  assign state   = state_r;
  assign irq     = irq_r;
  assign clr_ack = ack_r;

endmodule
